// File: rtl/matmul_controller.sv
// Sequencer for a four-lane MAC array computing C = W*X one output column at a time.
// Latency: K+3 cycles per column (CLEAR, K x RUN, DRAIN, OUT) with res_ready held high.
// Backpressure: holds the column in OUT with no memory reads until res_ready; optional perf counter under MATMUL_CTRL_PERF_EN.
module matmul_controller #(
    parameter int DIM_W  = 8,
    parameter int ADDR_W = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [DIM_W-1:0]   k_len,
    input  logic [DIM_W-1:0]   n_len,
    output logic               busy,
    output logic               done,
    output logic               mem_rd_en,
    output logic [ADDR_W-1:0]  w_addr,
    output logic [ADDR_W-1:0]  x_addr,
    output logic               mac_clear,
    output logic               mac_valid,
    input  logic signed [15:0] mac_out_1,
    input  logic signed [15:0] mac_out_2,
    input  logic signed [15:0] mac_out_3,
    input  logic signed [15:0] mac_out_4,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [63:0]        res_data,
    output logic [DIM_W-1:0]   res_col
`ifdef MATMUL_CTRL_PERF_EN
    ,
    output logic [31:0]        perf_cycles
`endif
);

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, OUT} state_t;

    state_t             state, state_nxt;
    logic [DIM_W-1:0]   k, k_nxt, n, n_nxt;
    logic [DIM_W-1:0]   k_len_q, k_len_nxt, n_len_q, n_len_nxt;
    logic [ADDR_W-1:0]  x_base, x_base_nxt;
    logic               done_nxt, rd_nxt, clr_nxt, val_nxt, rv_nxt;
    logic [ADDR_W-1:0]  wa_nxt, xa_nxt;
    logic [63:0]        rdat_nxt;
    logic [DIM_W-1:0]   rcol_nxt;
    logic [DIM_W:0]     k_p1, k_p2, n_p1, kl_ext, nl_ext;
    logic               job_ok;

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        state_nxt  = state;
        k_nxt      = k;
        n_nxt      = n;
        k_len_nxt  = k_len_q;
        n_len_nxt  = n_len_q;
        x_base_nxt = x_base;
        done_nxt   = 1'b0;
        rd_nxt     = 1'b0;
        clr_nxt    = 1'b0;
        val_nxt    = 1'b0;
        wa_nxt     = w_addr;
        xa_nxt     = x_addr;
        rv_nxt     = res_valid;
        rdat_nxt   = res_data;
        rcol_nxt   = res_col;
        k_p1       = {1'b0, k} + 1'b1;
        k_p2       = k_p1 + 1'b1;
        n_p1       = {1'b0, n} + 1'b1;
        kl_ext     = {1'b0, k_len_q};
        nl_ext     = {1'b0, n_len_q};
        job_ok     = (k_len != '0) && (n_len != '0);

        case (state)
            IDLE: begin
                if (start) begin
                    if (job_ok) begin
                        k_len_nxt  = k_len;
                        n_len_nxt  = n_len;
                        n_nxt      = '0;
                        x_base_nxt = '0;
                        state_nxt  = CLEAR;
                        clr_nxt    = 1'b1;
                        rd_nxt     = 1'b1;
                        wa_nxt     = '0;
                        xa_nxt     = '0;
                    end else begin
                        // Degenerate job: report completion without touching memory.
                        done_nxt = 1'b1;
                    end
                end
            end
            CLEAR: begin
                // First RUN cycle consumes word 0 and prefetches word 1 if it exists.
                k_nxt     = '0;
                state_nxt = RUN;
                val_nxt   = 1'b1;
                if (kl_ext > 1) begin
                    rd_nxt = 1'b1;
                    wa_nxt = ADDR_W'(1);
                    xa_nxt = x_base + ADDR_W'(1);
                end
            end
            RUN: begin
                if (k_p1 < kl_ext) begin
                    k_nxt   = k_p1[DIM_W-1:0];
                    val_nxt = 1'b1;
                    if (k_p2 < kl_ext) begin
                        rd_nxt = 1'b1;
                        wa_nxt = ADDR_W'(k_p2);
                        xa_nxt = x_base + ADDR_W'(k_p2);
                    end
                end else begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Array output has absorbed the last valid by now.
                state_nxt = OUT;
                rv_nxt    = 1'b1;
                rdat_nxt  = {mac_out_4, mac_out_3, mac_out_2, mac_out_1};
                rcol_nxt  = n;
            end
            OUT: begin
                if (res_ready) begin
                    rv_nxt = 1'b0;
                    if (n_p1 < nl_ext) begin
                        n_nxt      = n_p1[DIM_W-1:0];
                        x_base_nxt = x_base + ADDR_W'(k_len_q);
                        state_nxt  = CLEAR;
                        clr_nxt    = 1'b1;
                        rd_nxt     = 1'b1;
                        wa_nxt     = '0;
                        xa_nxt     = x_base + ADDR_W'(k_len_q);
                    end else begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            k         <= '0;
            n         <= '0;
            k_len_q   <= '0;
            n_len_q   <= '0;
            x_base    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_rd_en <= 1'b0;
            w_addr    <= '0;
            x_addr    <= '0;
            mac_clear <= 1'b0;
            mac_valid <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_col   <= '0;
        end else begin
            state     <= state_nxt;
            k         <= k_nxt;
            n         <= n_nxt;
            k_len_q   <= k_len_nxt;
            n_len_q   <= n_len_nxt;
            x_base    <= x_base_nxt;
            busy      <= (state_nxt != IDLE);
            done      <= done_nxt;
            mem_rd_en <= rd_nxt;
            w_addr    <= wa_nxt;
            x_addr    <= xa_nxt;
            mac_clear <= clr_nxt;
            mac_valid <= val_nxt;
            res_valid <= rv_nxt;
            res_data  <= rdat_nxt;
            res_col   <= rcol_nxt;
        end
    end

`ifdef MATMUL_CTRL_PERF_EN
    // Job cycle counter: the accepting cycle counts as the first, then every busy cycle, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cycles <= '0;
        end else if (state == IDLE && start) begin
            perf_cycles <= job_ok ? 32'd1 : 32'd0;
        end else if (busy && perf_cycles != 32'hFFFF_FFFF) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_matmul_controller.sv
// Bench for matmul_controller with behavioural memories and MAC array.
// Table of jobs with hand-computed results, plus reset, zero-length and backpressure sequences.
// Inputs driven and outputs sampled on the falling edge.
module tb_matmul_controller;

    logic              clk = 1'b0;
    logic              rst, start, res_ready;
    logic [7:0]        k_len, n_len, res_col;
    logic              busy, done, mem_rd_en, mac_clear, mac_valid, res_valid;
    logic [11:0]       w_addr, x_addr;
    logic signed [15:0] acc [4];
    logic [63:0]       res_data;
`ifdef MATMUL_CTRL_PERF_EN
    logic [31:0]       perf_cycles;
`endif

    int n_chk = 0;
    int n_fail = 0;

    int wm [4][256];
    int xm [256];
    int wd [4];
    int xd;

    typedef struct {
        int k;
        int n;
        int w   [4][4];   // w[lane][k]
        int x   [4][4];   // x[col][k]
        int exp [4][4];   // exp[col][lane]
    } vec_t;
    vec_t vecs [4];

    matmul_controller dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .n_len(n_len),
        .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .w_addr(w_addr), .x_addr(x_addr),
        .mac_clear(mac_clear), .mac_valid(mac_valid),
        .mac_out_1(acc[0]), .mac_out_2(acc[1]), .mac_out_3(acc[2]), .mac_out_4(acc[3]),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_col(res_col)
`ifdef MATMUL_CTRL_PERF_EN
        , .perf_cycles(perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous-read memories, one cycle latency.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            for (int l = 0; l < 4; l++) wd[l] <= wm[l][w_addr[7:0]];
            xd <= xm[x_addr[7:0]];
        end
    end

    // Four-lane MAC array with shared clear/valid.
    always @(posedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (mac_clear)      acc[l] <= 16'sd0;
            else if (mac_valid) acc[l] <= acc[l] + 16'(wd[l] * xd);
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load(input int v);
        for (int a = 0; a < 256; a++) begin
            xm[a] = 0;
            for (int l = 0; l < 4; l++) wm[l][a] = 0;
        end
        for (int kk = 0; kk < vecs[v].k; kk++) begin
            for (int l = 0; l < 4; l++) wm[l][kk] = vecs[v].w[l][kk];
            for (int c = 0; c < vecs[v].n; c++) xm[c * vecs[v].k + kk] = vecs[v].x[c][kk];
        end
    endtask

    task automatic run_job(input int v, input int stall, input bit timing, input bit inject);
        int K, N, col, rdk, rdc, stall_left, first_v, done_cyc;
        logic [63:0] snap;
        bit seen, expect_clear;
        K = vecs[v].k; N = vecs[v].n;
        col = 0; rdk = 0; rdc = 0; stall_left = stall;
        first_v = -1; done_cyc = -1; seen = 0; expect_clear = 0; snap = '0;
        load(v);
        @(negedge clk);
        k_len = 8'(K); n_len = 8'(N); start = 1'b1; res_ready = 1'b1;
        for (int cyc = 1; cyc < 500; cyc++) begin
            @(negedge clk);
            start = inject && (cyc == 3);
            k_len = 8'($urandom_range(1, 255));
            n_len = 8'($urandom_range(1, 255));
            if (expect_clear) begin
                check("clear_after_accept", mac_clear, 1);
                expect_clear = 0;
            end
            if (mac_clear && mac_valid) check("clear_valid_exclusive", 1, 0);
            if (mem_rd_en) begin
                check("w_addr", w_addr, rdk);
                check("x_addr", x_addr, rdc * K + rdk);
                rdk++;
                if (rdk == K) begin rdk = 0; rdc++; end
            end
            if (done) begin
                done_cyc = cyc;
                check("done_cols", col, N);
                check("done_busy", busy, 0);
                check("done_reads", rdc, N);
                break;
            end
            if (res_valid) begin
                check("out_no_read", mem_rd_en, 0);
                if (!seen) begin
                    seen = 1;
                    snap = res_data;
                    if (first_v < 0) first_v = cyc;
                    for (int l = 0; l < 4; l++)
                        check($sformatf("lane%0d_col%0d", l + 1, col),
                              longint'($signed(res_data[16*l +: 16])), vecs[v].exp[col][l]);
                    check("res_col", res_col, col);
                end else begin
                    check("res_stable", res_data, snap);
                end
                if (stall_left > 0) begin
                    res_ready = 1'b0;
                    stall_left--;
                end else begin
                    res_ready = 1'b1;
                    col++;
                    seen = 0;
                    if (col < N) expect_clear = 1;
                end
            end
        end
        if (done_cyc < 0) check("done_timeout", 0, 1);
        if (timing) begin
            check("first_valid_cycle", first_v, 5);
            check("done_cycle", done_cyc, 6);
        end
        @(negedge clk);
        check("done_one_pulse", done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0].k = 2; vecs[0].n = 1;
        vecs[0].w = '{'{1, 2, 0, 0}, '{3, 4, 0, 0}, '{5, 6, 0, 0}, '{7, 8, 0, 0}};
        vecs[0].x = '{'{1, 1, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
        vecs[0].exp = '{'{3, 7, 11, 15}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};

        vecs[1].k = 3; vecs[1].n = 2;
        vecs[1].w = '{'{-1, 2, -3, 0}, '{1, 1, 1, 0}, '{0, 0, 0, 0}, '{2, -1, 4, 0}};
        vecs[1].x = '{'{1, 1, 1, 0}, '{-2, 0, 5, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
        vecs[1].exp = '{'{-2, 3, 0, 5}, '{-13, 3, 0, 16}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};

        vecs[2].k = 1; vecs[2].n = 3;
        vecs[2].w = '{'{2, 0, 0, 0}, '{-3, 0, 0, 0}, '{4, 0, 0, 0}, '{5, 0, 0, 0}};
        vecs[2].x = '{'{7, 0, 0, 0}, '{-1, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
        vecs[2].exp = '{'{14, -21, 28, 35}, '{-2, 3, -4, -5}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};

        vecs[3].k = 4; vecs[3].n = 1;
        vecs[3].w = '{'{1, 1, 1, 1}, '{1, 2, 3, 4}, '{-1, -1, -1, -1}, '{100, 200, 300, 400}};
        vecs[3].x = '{'{1, 2, 3, 4}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
        vecs[3].exp = '{'{10, 30, -10, 3000}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};

        rst = 1'b1; start = 1'b0; res_ready = 1'b1; k_len = '0; n_len = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", mem_rd_en, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        rst = 1'b0;

        // Table-driven jobs: timing on the first, busy start on the second, backpressure on the third.
        for (int v = 0; v < 4; v++) begin
            run_job(v, (v == 2) ? 10 : 0, v == 0, v == 1);
`ifdef MATMUL_CTRL_PERF_EN
            if (v == 0) check("perf_cycles", perf_cycles, 6);
`endif
        end

        // Zero-length jobs: single done pulse, no reads, never busy.
        for (int z = 0; z < 2; z++) begin
            @(negedge clk);
            k_len = (z == 0) ? 8'd0 : 8'd5;
            n_len = (z == 0) ? 8'd3 : 8'd0;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("zero_done", done, 1);
            check("zero_rd_en", mem_rd_en, 0);
            check("zero_busy", busy, 0);
            @(negedge clk);
            check("zero_done_pulse", done, 0);
            check("zero_rd_en2", mem_rd_en, 0);
        end

        // Reset during RUN of a K=4 job, then a clean rerun.
        load(3);
        @(negedge clk);
        k_len = 8'd4; n_len = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_rd_en", mem_rd_en, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rd_en", mem_rd_en, 0);
        check("mid_rst_w_addr", w_addr, 0);
        check("mid_rst_x_addr", x_addr, 0);
        check("mid_rst_valid", mac_valid, 0);
        check("mid_rst_clear", mac_clear, 0);
        check("mid_rst_res_valid", res_valid, 0);
        check("mid_rst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("post_rst_done", done, 0);
            check("post_rst_busy", busy, 0);
        end
        run_job(3, 0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
